seq_divider32: RTL and testbench

- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the 32-bit ALU/multiplier path: it undoes multiplication and produces a quotient and a remainder.
- It sits beside the ALU. A start/done handshake connects it to the controller or testbench.
- It computes one quotient bit per clock, so a full-width divide takes WIDTH cycles.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/div_step_datapath.sv | 25 ++
 rtl/seq_divider32.sv | 143 ++++++++++++++
 tb/tb_seq_divider32.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - state encoding, default width and counter sizing for seq_divider32
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step_datapath.sv
// rtl/div_step_datapath.sv - one restoring-division iteration: shift {R,Q}, trial subtract, select
module div_step_datapath
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_next,
  output logic [WIDTH-1:0] o_quo_next
);

  logic [WIDTH:0]   w_rem_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_diff;

  assign w_rem_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_fits      = (w_rem_shift >= {1'b0, i_divisor});
  // A successful subtract always lands below the divisor, so WIDTH bits of the difference are exact.
  assign w_diff      = w_rem_shift[WIDTH-1:0] - i_divisor;
  assign o_rem_next  = w_fits ? w_diff : w_rem_shift[WIDTH-1:0];
  assign o_quo_next  = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/seq_divider32.sv
// rtl/seq_divider32.sv - multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to add the i_signed_op two's-complement mode.
module seq_divider32
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             i_signed_op,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_dvd_op;
  logic [WIDTH-1:0] w_dvs_op;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_q;
  logic w_neg_r;

  // Iterate on magnitudes; signs are reapplied on the last iteration so latency is unchanged.
  assign w_neg_r   = i_signed_op & i_dividend[WIDTH-1];
  assign w_neg_q   = i_signed_op & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
  assign w_dvd_op  = w_neg_r ? -i_dividend : i_dividend;
  assign w_dvs_op  = (i_signed_op & i_divisor[WIDTH-1]) ? -i_divisor : i_divisor;
  assign w_q_final = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_final = r_neg_r ? -w_rem_next : w_rem_next;
`else
  assign w_dvd_op  = i_dividend;
  assign w_dvs_op  = i_divisor;
  assign w_q_final = w_quo_next;
  assign w_r_final = w_rem_next;
`endif

  div_step_datapath #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem      (r_rem),
    .i_quo      (r_quo),
    .i_divisor  (r_divisor),
    .o_rem_next (w_rem_next),
    .o_quo_next (w_quo_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            if (i_divisor == '0) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_quotient  <= '1;
              r_remainder <= i_dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state   <= RUN;
              r_busy    <= 1'b1;
              r_dbz     <= 1'b0;
              r_cnt     <= CNT_W'(WIDTH);
              r_rem     <= '0;
              r_quo     <= w_dvd_op;
              r_divisor <= w_dvs_op;
`ifdef SEQ_DIVIDER_SIGNED_EN
              r_neg_q   <= w_neg_q;
              r_neg_r   <= w_neg_r;
`endif
            end
          end
        end
        RUN: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_final;
            r_remainder <= w_r_final;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider32.sv
// tb/tb_seq_divider32.sv - randomized self-checking bench for seq_divider32 (SEQ_DIVIDER_SIGNED_EN aware)
module tb_seq_divider32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic         signed_op;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider32 dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .i_signed_op   (signed_op),
`endif
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  // Reference: plain language arithmetic; returns {quotient, remainder}.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic so);
    longint sa, sb, sq, sr;
    if (b == '0) return {{W{1'b1}}, a};
    if (!so) return {a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sq = sa / sb;
    sr = sa % sb;
    return {sq[W-1:0], sr[W-1:0]};
  endfunction

  // Issues one start pulse from idle, returns results and the edge index (after the start edge) of done.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z, output int lat);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    q = quotient; r = remainder; z = dbz;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (quotient !== '0) begin n_err++; $display("FAIL reset_quotient got %h exp 0", quotient); end
    n_vec++; if (remainder !== '0) begin n_err++; $display("FAIL reset_remainder got %h exp 0", remainder); end
    n_vec++; if (dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b exp 0", dbz); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL idle_no_start got busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_basic();
    int first_done;
    int busy_gaps;
    first_done = -1; busy_gaps = 0;
    start = 1'b1; dividend = 100; divisor = 7;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_start got %b exp 1", busy); end
    for (int k = 1; k <= 32; k++) begin
      if (k < 32 && busy !== 1'b1) busy_gaps++;
      @(posedge clk); #1;
      if (done === 1'b1 && first_done < 0) first_done = k;
    end
    n_vec++; if (first_done !== 32) begin n_err++; $display("FAIL basic_latency got %0d exp 32", first_done); end
    n_vec++; if (busy_gaps !== 0) begin n_err++; $display("FAIL basic_busy_held got %0d gaps exp 0", busy_gaps); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
    n_vec++; if (quotient !== 32'd14) begin n_err++; $display("FAIL basic_quotient got %0d exp 14", quotient); end
    n_vec++; if (remainder !== 32'd2) begin n_err++; $display("FAIL basic_remainder got %0d exp 2", remainder); end
    n_vec++; if (dbz !== 1'b0) begin n_err++; $display("FAIL basic_dbz got %b exp 0", dbz); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_back_to_back();
    int e1, e2, ndone;
    logic [W-1:0] q1, r1, q2, r2;
    logic busy33, busy34;
    e1 = -1; e2 = -1; ndone = 0; q1 = 'x; r1 = 'x; q2 = 'x; r2 = 'x; busy33 = 1'bx; busy34 = 1'bx;
    start = 1'b1; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
    @(posedge clk); #1;
    dividend = 32'h0000_0a40; divisor = 32'h0000_0f13;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k == 33) busy33 = busy;
      if (k == 34) busy34 = busy;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin e1 = k; q1 = quotient; r1 = remainder; end
        if (ndone == 2) begin e2 = k; q2 = quotient; r2 = remainder; start = 1'b0; end
      end
    end
    start = 1'b0;
    n_vec++; if (e1 !== 32) begin n_err++; $display("FAIL b2b_first_latency got %0d exp 32", e1); end
    n_vec++; if (q1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_q1 got %h exp ffffffff", q1); end
    n_vec++; if (r1 !== 32'h0) begin n_err++; $display("FAIL b2b_r1 got %h exp 0", r1); end
    n_vec++; if (busy33 !== 1'b0) begin n_err++; $display("FAIL b2b_busy_in_done got %b exp 0", busy33); end
    n_vec++; if (busy34 !== 1'b1) begin n_err++; $display("FAIL b2b_busy_after_accept got %b exp 1", busy34); end
    n_vec++; if (e2 !== 66) begin n_err++; $display("FAIL b2b_second_done_edge got %0d exp 66", e2); end
    n_vec++; if (q2 !== 32'h0) begin n_err++; $display("FAIL b2b_q2 got %h exp 0", q2); end
    n_vec++; if (r2 !== 32'h0000_0a40) begin n_err++; $display("FAIL b2b_r2 got %h exp 00000a40", r2); end
    n_vec++; if (ndone !== 2) begin n_err++; $display("FAIL b2b_done_count got %0d exp 2", ndone); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r, a, b;
    logic [2*W-1:0] e;
    logic z;
    int lat;
    do_div(32'h1234_5678, 32'h0, q, r, z, lat);
    n_vec++; if (lat !== 0) begin n_err++; $display("FAIL dbz_latency got %0d exp 0", lat); end
    n_vec++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dbz_quotient got %h exp ffffffff", q); end
    n_vec++; if (r !== 32'h1234_5678) begin n_err++; $display("FAIL dbz_remainder got %h exp 12345678", r); end
    n_vec++; if (z !== 1'b1) begin n_err++; $display("FAIL dbz_flag got %b exp 1", z); end
    n_vec++; if (dbz !== 1'b1) begin n_err++; $display("FAIL dbz_flag_held got %b exp 1", dbz); end
    a = $urandom; b = $urandom_range(1, 1000);
    e = ref_div(a, b, 1'b0);
    do_div(a, b, q, r, z, lat);
    n_vec++; if (z !== 1'b0) begin n_err++; $display("FAIL dbz_cleared got %b exp 0", z); end
    n_vec++; if ({q, r} !== e) begin n_err++; $display("FAIL dbz_next_result got %h/%h exp %h/%h", q, r, e[2*W-1:W], e[W-1:0]); end
  endtask

  task automatic test_ignored_start();
    int first_done, ndone;
    logic [W-1:0] q, r;
    first_done = -1; ndone = 0; q = 'x; r = 'x;
    start = 1'b1; dividend = 1000; divisor = 3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      if (k == 10) begin start = 1'b1; dividend = 50; divisor = 5; end
      if (k == 11) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) begin first_done = k; q = quotient; r = remainder; end
      end
    end
    n_vec++; if (first_done !== 32) begin n_err++; $display("FAIL ign_latency got %0d exp 32", first_done); end
    n_vec++; if (q !== 32'd333) begin n_err++; $display("FAIL ign_quotient got %0d exp 333", q); end
    n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL ign_remainder got %0d exp 1", r); end
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL ign_done_count got %0d exp 1", ndone); end
  endtask

  task automatic test_reset_midrun();
    int ndone, lat;
    logic [W-1:0] q, r;
    logic z;
    ndone = 0;
    start = 1'b1; dividend = 1000; divisor = 3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_vec++; if (quotient !== '0) begin n_err++; $display("FAIL midrst_quotient got %h exp 0", quotient); end
    n_vec++; if (remainder !== '0) begin n_err++; $display("FAIL midrst_remainder got %h exp 0", remainder); end
    n_vec++; if (done !== 1'b0 || dbz !== 1'b0) begin n_err++; $display("FAIL midrst_done_dbz got %b/%b exp 0/0", done, dbz); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL midrst_no_done got %0d exp 0", ndone); end
    do_div(32'd1000, 32'd3, q, r, z, lat);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL midrst_fresh_latency got %0d exp 32", lat); end
    n_vec++; if (q !== 32'd333 || r !== 32'd1) begin n_err++; $display("FAIL midrst_fresh_result got %0d r %0d exp 333 r 1", q, r); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r;
    logic [2*W-1:0] e;
    logic z;
    int lat, mode;
    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 4);
      a = $urandom;
      case (mode)
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = '0;
        3: begin b = $urandom | 32'h8000_0000; a = $urandom_range(0, b - 1); end
        default: begin b = ($urandom_range(0, 1) == 0) ? 32'd1 : a; end
      endcase
      e = ref_div(a, b, 1'b0);
      do_div(a, b, q, r, z, lat);
      n_vec++; if (q !== e[2*W-1:W]) begin n_err++; $display("FAIL rand_q %h/%h got %h exp %h", a, b, q, e[2*W-1:W]); end
      n_vec++; if (r !== e[W-1:0]) begin n_err++; $display("FAIL rand_r %h/%h got %h exp %h", a, b, r, e[W-1:0]); end
      n_vec++; if (z !== (b == '0)) begin n_err++; $display("FAIL rand_dbz %h/%h got %b exp %b", a, b, z, (b == '0)); end
      n_vec++; if (lat !== ((b == '0) ? 0 : 32)) begin n_err++; $display("FAIL rand_latency %h/%h got %0d", a, b, lat); end
    end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] a, b, q, r;
    logic [2*W-1:0] e;
    logic z, so;
    int lat;
    signed_op = 1'b1;
    do_div(-32'sd7, 32'd2, q, r, z, lat);
    n_vec++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sgn_m7_2 got %h r %h exp fffffffd r ffffffff", q, r); end
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL sgn_latency got %0d exp 32", lat); end
    signed_op = 1'b0;
    do_div(-32'sd7, 32'd2, q, r, z, lat);
    n_vec++; if (q !== 32'h7FFF_FFFC || r !== 32'h1) begin n_err++; $display("FAIL uns_m7_2 got %h r %h exp 7ffffffc r 1", q, r); end
    signed_op = 1'b1;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, q, r, z, lat);
    n_vec++; if (q !== 32'h8000_0000 || r !== 32'h0 || z !== 1'b0) begin n_err++; $display("FAIL sgn_wrap got %h r %h z %b exp 80000000 r 0 z 0", q, r, z); end
    do_div(32'h8000_0005, 32'h0, q, r, z, lat);
    n_vec++; if (q !== 32'hFFFF_FFFF || r !== 32'h8000_0005 || z !== 1'b1) begin n_err++; $display("FAIL sgn_dbz got %h r %h z %b", q, r, z); end
    for (int i = 0; i < 60; i++) begin
      so = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
      e = ref_div(a, b, so);
      signed_op = so;
      do_div(a, b, q, r, z, lat);
      n_vec++; if ({q, r} !== e) begin n_err++; $display("FAIL sgn_rand so=%b %h/%h got %h r %h exp %h r %h", so, a, b, q, r, e[2*W-1:W], e[W-1:0]); end
    end
    signed_op = 1'b0;
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignored_start();
    test_reset_midrun();
    test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
